// File: rtl/l1_direct_mapped_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 32-byte lines.
// Hits complete in the request cycle; misses fill or evict over a 256-bit pmem port.
//
// state     | meaning
// IDLE      | serve hits, decide on miss handling
// WRITEBACK | evicting the dirty victim line to pmem
// FETCH     | filling the requested line from pmem
module l1_direct_mapped_cache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int S_OFFSET = 5;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int LINES    = 2 ** S_INDEX;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t             state;
  logic [255:0]       data_arr [LINES];
  logic [S_TAG-1:0]   tag_arr  [LINES];
  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;

  logic [S_TAG-1:0]   tag;
  logic [S_INDEX-1:0] idx;
  logic [2:0]         word;
  logic [7:0]         word_bit;
  logic               req;
  logic               hit;
  logic [31:0]        sel_word;
  logic [31:0]        merged_word;
  logic               unused_addr_bits;

  assign tag              = mem_address[31:S_INDEX+S_OFFSET];
  assign idx              = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
  assign word             = mem_address[4:2];
  assign word_bit         = {word, 5'b0};
  assign unused_addr_bits = ^mem_address[1:0];

  assign req      = mem_read | mem_write;
  assign hit      = valid[idx] && (tag_arr[idx] == tag);
  assign sel_word = data_arr[idx][word_bit +: 32];

  always_comb begin
    merged_word = sel_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  assign mem_resp     = (state == IDLE) && req && hit;
  assign mem_rdata    = sel_word;
  assign pmem_wdata   = data_arr[idx];
  assign pmem_address = (state == WRITEBACK) ? {tag_arr[idx], idx, 5'b0}
                                             : {mem_address[31:5], 5'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (mem_write && (mem_byte_enable != 4'b0)) dirty[idx] <= 1'b1;
          end else if (req) begin
            if (dirty[idx]) begin
              state      <= WRITEBACK;
              pmem_write <= 1'b1;
            end else begin
              state     <= FETCH;
              pmem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state      <= FETCH;
            pmem_write <= 1'b0;
            pmem_read  <= 1'b1;
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage carry no reset; validity alone guards their contents.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == IDLE && req && hit && mem_write) begin
        data_arr[idx][word_bit +: 32] <= merged_word;
      end else if (state == FETCH && pmem_resp) begin
        data_arr[idx] <= pmem_rdata;
        tag_arr[idx]  <= tag;
      end
    end
  end

endmodule

// File: tb/tb_l1_direct_mapped_cache.sv
// Directed bench for l1_direct_mapped_cache: bench drives pmem by hand and checks
// hit/miss timing, writeback contents and reset abort behaviour.
module tb_l1_direct_mapped_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  logic [255:0] line_a;
  logic [255:0] line_b;
  int checks = 0;
  int errors = 0;

  l1_direct_mapped_cache #(.S_INDEX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and return to the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: resp/pread/pwrite=%b want 000", {mem_resp, pmem_read, pmem_write});
    end
  endtask

  task automatic test_cold_read();
    mem_read = 1'b1; mem_address = 32'h40;
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin
      errors++; $display("FAIL cold_miss_resp: got %b want 0", mem_resp);
    end
    step(); #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h40) begin
      errors++;
      $display("FAIL cold_fetch: pread=%b pwrite=%b addr=%h want 1 0 00000040", pmem_read, pmem_write, pmem_address);
    end
    step(); step();
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || mem_resp !== 1'b0) begin
      errors++;
      $display("FAIL cold_fetch_hold: pread=%b pwrite=%b resp=%b want 1 0 0", pmem_read, pmem_write, mem_resp);
    end
    pmem_rdata = line_a; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'hDEADBEEF || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL cold_fill_resp: resp=%b rdata=%h pread=%b pwrite=%b want 1 deadbeef 0 0", mem_resp, mem_rdata, pmem_read, pmem_write);
    end
    step();
    mem_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp   [3];
    addrs[0] = 32'h40; addrs[1] = 32'h44; addrs[2] = 32'h5C;
    exp[0] = 32'hDEADBEEF; exp[1] = 32'hAAAAAAAA; exp[2] = 32'h10000007;
    mem_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_address = addrs[i];
      #1;
      checks++;
      if (mem_resp !== 1'b1 || mem_rdata !== exp[i] || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hit[%0d]: resp=%b rdata=%h pread=%b pwrite=%b want 1 %h 0 0", i, mem_resp, mem_rdata, pmem_read, pmem_write, exp[i]);
      end
      step();
    end
    mem_read = 1'b0;
  endtask

  task automatic test_write_hit();
    mem_write = 1'b1; mem_address = 32'h44; mem_byte_enable = 4'b0110; mem_wdata = 32'h11223344;
    #1;
    checks++;
    if (mem_resp !== 1'b1) begin
      errors++; $display("FAIL write_hit_resp: got %b want 1", mem_resp);
    end
    step();
    mem_write = 1'b0; mem_read = 1'b1;
    #1;
    checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'hAA2233AA) begin
      errors++; $display("FAIL write_hit_merge: resp=%b rdata=%h want 1 aa2233aa", mem_resp, mem_rdata);
    end
    step();
    mem_read = 1'b0;
  endtask

  task automatic test_conflict_writeback();
    mem_read = 1'b1; mem_address = 32'h140;
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin
      errors++; $display("FAIL conflict_miss_resp: got %b want 0", mem_resp);
    end
    step(); #1;
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h40) begin
      errors++;
      $display("FAIL wb_request: pwrite=%b pread=%b addr=%h want 1 0 00000040", pmem_write, pmem_read, pmem_address);
    end
    checks++;
    if (pmem_wdata[63:32] !== 32'hAA2233AA || pmem_wdata[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_data: w1=%h w0=%h want aa2233aa deadbeef", pmem_wdata[63:32], pmem_wdata[31:0]);
    end
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h140) begin
      errors++;
      $display("FAIL wb_then_fetch: pread=%b pwrite=%b addr=%h want 1 0 00000140", pmem_read, pmem_write, pmem_address);
    end
    pmem_rdata = line_b; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'h20000000) begin
      errors++; $display("FAIL conflict_fill_resp: resp=%b rdata=%h want 1 20000000", mem_resp, mem_rdata);
    end
    step();
    // The freshly filled line must be clean: evicting it goes straight to FETCH.
    mem_address = 32'h40;
    step(); #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h40) begin
      errors++;
      $display("FAIL line_clean_after_fill: pread=%b pwrite=%b addr=%h want 1 0 00000040", pmem_read, pmem_write, pmem_address);
    end
    pmem_rdata = line_a; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    step();
    mem_read = 1'b0;
  endtask

  task automatic test_read_write_both();
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h40;
    mem_byte_enable = 4'hF; mem_wdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (mem_resp !== 1'b1) begin
      errors++; $display("FAIL rw_both_resp: got %b want 1", mem_resp);
    end
    step();
    mem_write = 1'b0;
    #1;
    checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rw_both_as_write: resp=%b rdata=%h want 1 cafef00d", mem_resp, mem_rdata);
    end
    step();
    mem_read = 1'b0;
  endtask

  task automatic test_reset_abort();
    mem_read = 1'b1; mem_address = 32'h140;
    step(); #1;
    checks++;
    if (pmem_write !== 1'b1 || pmem_wdata[31:0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL dirty_evict: pwrite=%b w0=%h want 1 cafef00d", pmem_write, pmem_wdata[31:0]);
    end
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL abort_setup_fetch: pread=%b want 1", pmem_read);
    end
    rst_n = 1'b0; mem_read = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: resp/pread/pwrite=%b want 000", {mem_resp, pmem_read, pmem_write});
    end
    pmem_rdata = line_b; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      errors++;
      $display("FAIL stale_pmem_resp: resp/pread/pwrite=%b want 000", {mem_resp, pmem_read, pmem_write});
    end
    mem_read = 1'b1; mem_address = 32'h40;
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin
      errors++; $display("FAIL post_reset_miss: resp=%b want 0", mem_resp);
    end
    step(); #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h40) begin
      errors++;
      $display("FAIL post_reset_no_wb: pread=%b pwrite=%b addr=%h want 1 0 00000040", pmem_read, pmem_write, pmem_address);
    end
    pmem_rdata = line_a; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL post_reset_fill: resp=%b rdata=%h want 1 deadbeef", mem_resp, mem_rdata);
    end
    step();
    mem_read = 1'b0;
  endtask

  initial begin
    for (int w = 0; w < 8; w++) begin
      line_a[w*32 +: 32] = 32'h10000000 + w;
      line_b[w*32 +: 32] = 32'h20000000 + w;
    end
    line_a[31:0]  = 32'hDEADBEEF;
    line_a[63:32] = 32'hAAAAAAAA;
    @(negedge clk);
    test_reset();
    test_cold_read();
    test_back_to_back();
    test_write_hit();
    test_conflict_writeback();
    test_read_write_both();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_direct_mapped_cache.md
Name: l1_direct_mapped_cache

Overview:
- Responder side of the CPU memory interface: services `read`/`write`/`address`/`byte_enable`/`wdata` requests and returns `resp`/`rdata`.
- One instance sits behind the datapath's imem port and one behind its dmem port.
- Direct-mapped, write-back, write-allocate cache with 32-byte lines.
- Misses go to a 256-bit physical-memory port (arbiter or main memory model).

Parameters:
- S_INDEX, 3: index bits; number of lines = 2**S_INDEX.
- S_OFFSET, 5: byte-offset bits within a 32-byte line; fixed, not for override.
- S_TAG, 32-S_OFFSET-S_INDEX: tag width (derived).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_address  in  32  byte address; bits [1:0] ignored
- mem_byte_enable  in  4  write byte lanes; bit i enables wdata[8i+7:8i]
- mem_wdata  in  32  write data, lane-aligned
- mem_resp  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid when mem_resp=1
- pmem_read  out  1  line fill request; held until pmem_resp
- pmem_write  out  1  line writeback request; held until pmem_resp
- pmem_address  out  32  line address, bits [4:0]=0
- pmem_wdata  out  256  writeback line
- pmem_rdata  in  256  fill line, valid when pmem_resp=1
- pmem_resp  in  1  physical memory completion pulse

Behaviour:
- Address split: tag = mem_address[31:S_INDEX+5]; index = [S_INDEX+4:5]; word = [4:2].
- Storage:
  - Per line: valid bit, dirty bit, tag, 256-bit data.
  - Arrays are flops, read combinationally.
  - Word w of a line = data[32w+31:32w].
- Reset: on a clk edge with rst_n=0:
  - State goes to IDLE; all valid and dirty bits are cleared.
  - Tag and data arrays are not reset.
  - While in IDLE with no request: mem_resp=0, pmem_read=0, pmem_write=0.
  - Reset mid-FETCH or mid-WRITEBACK aborts; pmem_read/pmem_write are low from the cycle after that edge.
  - A pmem_resp arriving after the abort is ignored.
- A request is present when mem_read|mem_write.
  - Both asserted is treated as a write.
  - Hit = valid[index] & (tag_array[index]==tag).
- States:
  - IDLE
    - Request and hit: mem_resp=1 combinationally in the same cycle (0-cycle hit latency).
    - Read hit: mem_rdata = selected word.
    - Write hit: at that edge, each enabled byte of the selected word is updated; dirty[index] is set if byte_enable!=0. mem_rdata = selected word (pre-write), don't-care to the requester.
    - Request, miss, dirty[index]=0 -> FETCH.
    - Request, miss, dirty[index]=1 -> WRITEBACK.
    - No request -> IDLE.
  - WRITEBACK
    - Outputs: pmem_write=1; pmem_address = {tag_array[index], index, 5'b0}; pmem_wdata = data[index].
    - On pmem_resp -> FETCH; otherwise stay.
    - mem_resp=0.
  - FETCH
    - Outputs: pmem_read=1; pmem_address = {mem_address[31:5], 5'b0}.
    - On pmem_resp: data[index] = pmem_rdata; tag updated; valid=1; dirty=0; -> IDLE.
    - mem_resp=0.
    - Next cycle the held request hits (miss penalty = pmem latency + 1 cycle).
- mem_resp is asserted only in IDLE. A requester that keeps the request asserted after resp starts a new access in the following cycle.
- Request inputs must be stable from assertion to mem_resp; changes mid-miss are undefined.
- pmem_read and pmem_write are never asserted together.
- When idle, mem_rdata is don't-care; implementation drives the selected word of the current index.
- No write-through; data reaches pmem only on eviction.

Test Plan:
- Reset then cold read 0x0000_0040: 1 cycle IDLE miss -> FETCH with pmem_address=0x40. pmem_resp after 3 cycles with line word0=0xDEADBEEF -> next cycle mem_resp=1, mem_rdata=0xDEADBEEF. No pmem_write at any point.
- Back-to-back read hits 0x40, 0x44, 0x5C after that fill -> mem_resp high the same cycle as each request. No pmem activity. rdata equals line words 0, 1, 7.
- Write hit 0x44, byte_enable=4'b0110, wdata=0x11223344, old word 0xAAAAAAAA -> resp same cycle; read 0x44 returns 0xAA2233AA; dirty[2]=1.
- Conflict read 0x0000_0140 (same index 2, new tag) after dirtying -> WRITEBACK first: pmem_write, pmem_address=0x40, wdata word1=0xAA2233AA. Then FETCH 0x140, then resp. Line is clean afterwards.
- rst_n=0 for one edge while in FETCH, pmem_resp held low -> pmem_read=0 the next cycle, state IDLE. Repeat read 0x40 -> miss again (valid cleared), and no writeback, even though the line was dirty before reset.
- mem_read=1 and mem_write=1, byte_enable=4'hF, wdata=0xCAFEF00D on a hit -> handled as a write; subsequent read returns 0xCAFEF00D.
